// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the snake sequencing controller and its datapath:
// scan-side collision flags and the button pulse flow in, move/respawn
// strobes, direction, bookkeeping counters and FSM state flow out.
//
// Strobe semantics: there is no back-pressure on any signal. An input pulse
// (dir_pulse, frame_end) is consumed on the single master_clk edge where it
// is high. An output strobe (move_en, grow, apple_respawn) is valid for
// exactly one cycle and the consumer must act on it in that cycle.
interface snake_game_ctrl_if;
    logic       start;
    logic       dir_pulse;
    logic       frame_end;
    logic       hit_apple;
    logic       hit_lethal;
    logic       move_en;
    logic [4:0] direction;
    logic       body_clear;
    logic       apple_respawn;
    logic       grow;
    logic [6:0] size;
    logic [7:0] score;
    logic       game_over;
    logic [1:0] state;

    // Environment side: drives the controls, observes the controller.
    modport master (
        output start, dir_pulse, frame_end, hit_apple, hit_lethal,
        input  move_en, direction, body_clear, apple_respawn, grow,
               size, score, game_over, state
    );

    // Controller side.
    modport slave (
        input  start, dir_pulse, frame_end, hit_apple, hit_lethal,
        output move_en, direction, body_clear, apple_respawn, grow,
               size, score, game_over, state
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: master FSM, move-tick divider, one-deep turn queue,
// per-frame collision evaluation and size/score bookkeeping.
// Every output is a flop; the FSM state is exported on bus.state.
module snake_game_ctrl #(
    parameter int TICK_DIV = 1777777,
    parameter int MAX_SIZE = 16
) (
    input  logic              master_clk,
    input  logic              B_reset,
    snake_game_ctrl_if.slave  bus
);
    localparam int             TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [6:0]     SIZE_MAX  = 7'(MAX_SIZE);
    localparam logic [4:0]     DIR_UP    = 5'b00010;
    localparam logic [4:0]     DIR_RIGHT = 5'b10000;
    localparam logic [4:0]     DIR_DOWN  = 5'b01000;
    localparam logic [4:0]     DIR_LEFT  = 5'b00100;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DEAD = 2'b10,
        S_WIN  = 2'b11
    } state_t;

    // Clockwise rotation of a one-hot heading; an illegal code recovers to right.
    function automatic logic [4:0] rotate_cw(input logic [4:0] d);
        case (d)
            DIR_UP:    return DIR_RIGHT;
            DIR_RIGHT: return DIR_DOWN;
            DIR_DOWN:  return DIR_LEFT;
            DIR_LEFT:  return DIR_UP;
            default:   return DIR_RIGHT;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [4:0]    direction_q, direction_d;
    logic [4:0]    pending_q, pending_d;
    logic [6:0]    size_q, size_d;
    logic [7:0]    score_q, score_d;
    logic          armed_q, armed_d;
    logic          lethal_lat_q, lethal_lat_d;
    logic          apple_lat_q, apple_lat_d;
    logic          move_en_q, move_en_d;
    logic          grow_q, grow_d;
    logic          apple_respawn_q, apple_respawn_d;
    logic          game_over_q, game_over_d;
    logic          body_clear_q, body_clear_d;

    logic          eff_lethal;
    logic          eff_apple;
    logic          tick_wrap;
    logic          win_now;
    logic [6:0]    size_inc;
    logic [4:0]    turn_base;

    // Next-state logic; priority is start abort > lethal > apple > tick/turn.
    always_comb begin
        state_d         = state_q;
        tick_d          = tick_q;
        direction_d     = direction_q;
        pending_d       = pending_q;
        size_d          = size_q;
        score_d         = score_q;
        armed_d         = armed_q;
        lethal_lat_d    = lethal_lat_q;
        apple_lat_d     = apple_lat_q;
        move_en_d       = 1'b0;
        grow_d          = 1'b0;
        apple_respawn_d = 1'b0;
        game_over_d     = game_over_q;
        body_clear_d    = body_clear_q;

        // A frame's verdict includes a hit on the very pixel that ends it.
        eff_lethal = bus.frame_end & (lethal_lat_q | bus.hit_lethal);
        eff_apple  = bus.frame_end & (apple_lat_q | bus.hit_apple);
        tick_wrap  = (tick_q == TICK_LAST);
        size_inc   = size_q + 7'd1;
        win_now    = 1'b0;
        // On a move edge the heading is about to become pending, so a turn
        // request there is judged against the new heading.
        turn_base  = tick_wrap ? pending_q : direction_q;

        if (!bus.start) begin
            // Abort/idle from any state; score stays visible until next start.
            state_d      = S_IDLE;
            body_clear_d = 1'b1;
            size_d       = 7'd1;
            game_over_d  = 1'b0;
            direction_d  = DIR_RIGHT;
            pending_d    = DIR_RIGHT;
            tick_d       = '0;
            armed_d      = 1'b0;
            lethal_lat_d = 1'b0;
            apple_lat_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d         = S_RUN;
                    body_clear_d    = 1'b0;
                    size_d          = 7'd1;
                    game_over_d     = 1'b0;
                    direction_d     = DIR_RIGHT;
                    pending_d       = DIR_RIGHT;
                    score_d         = 8'd0;
                    tick_d          = '0;
                    armed_d         = 1'b0;
                    lethal_lat_d    = 1'b0;
                    apple_lat_d     = 1'b0;
                    apple_respawn_d = 1'b1;
                end
                S_RUN: begin
                    body_clear_d = 1'b0;
                    if (bus.frame_end) begin
                        lethal_lat_d = 1'b0;
                        apple_lat_d  = 1'b0;
                    end else begin
                        lethal_lat_d = lethal_lat_q | bus.hit_lethal;
                        apple_lat_d  = apple_lat_q | bus.hit_apple;
                    end

                    if (eff_lethal) begin
                        state_d     = S_DEAD;
                        game_over_d = 1'b1;
                    end else begin
                        // Only one growth per move step: armed is re-set by the tick.
                        if (eff_apple && armed_q) begin
                            grow_d          = 1'b1;
                            apple_respawn_d = 1'b1;
                            size_d          = size_inc;
                            score_d         = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                            armed_d         = 1'b0;
                            if (size_inc == SIZE_MAX) begin
                                win_now = 1'b1;
                                state_d = S_WIN;
                            end
                        end
                        if (!win_now) begin
                            if (tick_wrap) begin
                                tick_d      = '0;
                                move_en_d   = 1'b1;
                                direction_d = pending_q;
                                armed_d     = 1'b1;
                            end else begin
                                tick_d = tick_q + TW'(1);
                            end
                            // One queued turn at most; blocks a reversal in one step.
                            if (bus.dir_pulse && (pending_q == turn_base)) begin
                                pending_d = rotate_cw(pending_q);
                            end
                        end
                    end
                end
                S_DEAD: begin
                    game_over_d = 1'b1;
                end
                S_WIN: begin
                    game_over_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge master_clk) begin
        if (B_reset) begin
            state_q         <= S_IDLE;
            tick_q          <= '0;
            direction_q     <= DIR_RIGHT;
            pending_q       <= DIR_RIGHT;
            size_q          <= 7'd1;
            score_q         <= 8'd0;
            armed_q         <= 1'b0;
            lethal_lat_q    <= 1'b0;
            apple_lat_q     <= 1'b0;
            move_en_q       <= 1'b0;
            grow_q          <= 1'b0;
            apple_respawn_q <= 1'b0;
            game_over_q     <= 1'b0;
            body_clear_q    <= 1'b1;
        end else begin
            state_q         <= state_d;
            tick_q          <= tick_d;
            direction_q     <= direction_d;
            pending_q       <= pending_d;
            size_q          <= size_d;
            score_q         <= score_d;
            armed_q         <= armed_d;
            lethal_lat_q    <= lethal_lat_d;
            apple_lat_q     <= apple_lat_d;
            move_en_q       <= move_en_d;
            grow_q          <= grow_d;
            apple_respawn_q <= apple_respawn_d;
            game_over_q     <= game_over_d;
            body_clear_q    <= body_clear_d;
        end
    end

    assign bus.move_en       = move_en_q;
    assign bus.direction     = direction_q;
    assign bus.body_clear    = body_clear_q;
    assign bus.apple_respawn = apple_respawn_q;
    assign bus.grow          = grow_q;
    assign bus.size          = size_q;
    assign bus.score         = score_q;
    assign bus.game_over     = game_over_q;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl with TICK_DIV=4, MAX_SIZE=3. Stimulus pushes the
// hand-derived output snapshot of every expected event; the monitor pops one
// whenever a strobe fires, the state changes, or a probe is requested.
module tb_snake_game_ctrl;
    localparam int TICK_DIV = 4;
    localparam int MAX_SIZE = 3;

    logic clk;
    logic b_reset;
    logic probe;
    logic mon_en;
    int   n_vec;
    int   n_err;
    int   edge_n;
    int   base;

    logic [26:0] exp_q[$];

    snake_game_ctrl_if bus ();

    snake_game_ctrl #(
        .TICK_DIV (TICK_DIV),
        .MAX_SIZE (MAX_SIZE)
    ) dut (
        .master_clk (clk),
        .B_reset    (b_reset),
        .bus        (bus)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit hit, got timeout, expected summary");
        $fatal(1, "watchdog");
    end

    // Snapshot: {move_en, grow, apple_respawn, game_over, body_clear, state, direction, size, score}
    function automatic logic [26:0] ev(input logic m, input logic g, input logic r,
                                       input logic go, input logic bc, input logic [1:0] st,
                                       input logic [4:0] d, input logic [6:0] sz,
                                       input logic [7:0] sc);
        return {m, g, r, go, bc, st, d, sz, sc};
    endfunction

    task automatic push(input logic [26:0] e);
        exp_q.push_back(e);
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Advance so that the next cyc1 is edge k counted from the latest start edge.
    task automatic run_to(input int k);
        while (edge_n - base < k - 1) cyc1();
    endtask

    task automatic drive_at(input int k, input logic dp, input logic fe,
                            input logic ha, input logic hl);
        run_to(k);
        bus.dir_pulse  = dp;
        bus.frame_end  = fe;
        bus.hit_apple  = ha;
        bus.hit_lethal = hl;
        cyc1();
        bus.dir_pulse  = 1'b0;
        bus.frame_end  = 1'b0;
        bus.hit_apple  = 1'b0;
        bus.hit_lethal = 1'b0;
    endtask

    task automatic start_at(input int k, input logic v);
        run_to(k);
        bus.start = v;
        cyc1();
        if (v) base = edge_n;
    endtask

    // Monitor / scoreboard
    initial begin
        logic [1:0]  prev_state;
        logic [26:0] act;
        logic [26:0] exp_v;
        int          gap;
        bit          seen_move;
        gap = 0;
        seen_move = 1'b0;
        prev_state = 2'b00;
        forever begin
            @(negedge clk);
            act = {bus.move_en, bus.grow, bus.apple_respawn, bus.game_over, bus.body_clear,
                   bus.state, bus.direction, bus.size, bus.score};
            if (mon_en) begin
                if (bus.state == 2'b01) begin
                    gap++;
                    if (bus.move_en) begin
                        if (seen_move) begin
                            n_vec++;
                            if (gap != TICK_DIV) begin
                                n_err++;
                                $display("FAIL move_period: got %0d cycles, expected %0d", gap, TICK_DIV);
                            end
                        end
                        seen_move = 1'b1;
                        gap = 0;
                    end
                end else begin
                    seen_move = 1'b0;
                    gap = 0;
                end
                if (probe || bus.move_en || bus.grow || bus.apple_respawn || bus.state != prev_state) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_event @%0t: got %h, expected no event", $time, act);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (act !== exp_v) begin
                            n_err++;
                            $display("FAIL event @%0t: got m%b g%b r%b go%b bc%b st%b dir%b sz%0d sc%0d, expected m%b g%b r%b go%b bc%b st%b dir%b sz%0d sc%0d",
                                     $time, act[26], act[25], act[24], act[23], act[22], act[21:20],
                                     act[19:15], act[14:8], act[7:0],
                                     exp_v[26], exp_v[25], exp_v[24], exp_v[23], exp_v[22], exp_v[21:20],
                                     exp_v[19:15], exp_v[14:8], exp_v[7:0]);
                        end
                    end
                end
            end
            prev_state = bus.state;
        end
    end

    // Stimulus
    initial begin
        n_vec = 0;
        n_err = 0;
        edge_n = 0;
        base = 0;
        probe = 1'b0;
        mon_en = 1'b0;
        b_reset = 1'b1;
        bus.start = 1'b0;
        bus.dir_pulse = 1'b0;
        bus.frame_end = 1'b0;
        bus.hit_apple = 1'b0;
        bus.hit_lethal = 1'b0;
        cyc1();
        cyc1();
        b_reset = 1'b0;

        // Reset values, then start
        push(ev(0, 0, 0, 0, 1, 2'b00, 5'b10000, 7'd1, 8'd0));
        push(ev(0, 0, 1, 0, 0, 2'b01, 5'b10000, 7'd1, 8'd0));
        mon_en = 1'b1;
        probe = 1'b1;
        bus.start = 1'b1;
        cyc1();
        probe = 1'b0;
        base = edge_n;

        // Session 1: turns, apple growth, repeat apple ignored, lethal, abort
        push(ev(1, 0, 0, 0, 0, 2'b01, 5'b10000, 7'd1, 8'd0)); // k4
        push(ev(1, 0, 0, 0, 0, 2'b01, 5'b01000, 7'd1, 8'd0)); // k8
        push(ev(1, 0, 0, 0, 0, 2'b01, 5'b00100, 7'd1, 8'd0)); // k12
        push(ev(1, 0, 0, 0, 0, 2'b01, 5'b00100, 7'd1, 8'd0)); // k16
        push(ev(0, 1, 1, 0, 0, 2'b01, 5'b00100, 7'd2, 8'd1)); // k17 grow
        push(ev(1, 0, 0, 0, 0, 2'b01, 5'b00100, 7'd2, 8'd1)); // k20
        push(ev(0, 0, 0, 1, 0, 2'b10, 5'b00100, 7'd2, 8'd1)); // k21 dead
        push(ev(0, 0, 0, 0, 1, 2'b00, 5'b10000, 7'd1, 8'd1)); // k31 idle
        drive_at(5, 1, 0, 0, 0);
        drive_at(7, 1, 0, 0, 0);
        drive_at(10, 1, 0, 0, 0);
        drive_at(13, 0, 0, 1, 0);
        drive_at(14, 0, 0, 1, 0);
        drive_at(15, 0, 0, 1, 0);
        drive_at(17, 0, 1, 0, 0);
        drive_at(18, 0, 0, 1, 0);
        drive_at(19, 0, 1, 0, 0);
        drive_at(21, 0, 1, 1, 1);
        drive_at(25, 1, 0, 0, 0);
        start_at(31, 1'b0);

        // Session 2: two armed apples reach MAX_SIZE
        push(ev(0, 0, 1, 0, 0, 2'b01, 5'b10000, 7'd1, 8'd0)); // start
        push(ev(1, 0, 0, 0, 0, 2'b01, 5'b10000, 7'd1, 8'd0)); // +4
        push(ev(0, 1, 1, 0, 0, 2'b01, 5'b10000, 7'd2, 8'd1)); // +5
        push(ev(1, 0, 0, 0, 0, 2'b01, 5'b10000, 7'd2, 8'd1)); // +8
        push(ev(0, 1, 1, 0, 0, 2'b11, 5'b10000, 7'd3, 8'd2)); // +9 win
        push(ev(0, 0, 0, 0, 1, 2'b00, 5'b10000, 7'd1, 8'd2)); // +21 idle
        start_at(33, 1'b1);
        drive_at(5, 0, 1, 1, 0);
        drive_at(9, 0, 1, 1, 0);
        start_at(21, 1'b0);

        // Session 3: abort mid-run keeps score
        push(ev(0, 0, 1, 0, 0, 2'b01, 5'b10000, 7'd1, 8'd0));
        push(ev(1, 0, 0, 0, 0, 2'b01, 5'b10000, 7'd1, 8'd0)); // +4
        push(ev(0, 1, 1, 0, 0, 2'b01, 5'b10000, 7'd2, 8'd1)); // +5
        push(ev(0, 0, 0, 0, 1, 2'b00, 5'b10000, 7'd1, 8'd1)); // +6 idle
        start_at(23, 1'b1);
        drive_at(5, 0, 1, 1, 0);
        start_at(6, 1'b0);

        // Session 4: turn, then reset mid-run
        push(ev(0, 0, 1, 0, 0, 2'b01, 5'b10000, 7'd1, 8'd0));
        push(ev(1, 0, 0, 0, 0, 2'b01, 5'b10000, 7'd1, 8'd0)); // +4
        push(ev(1, 0, 0, 0, 0, 2'b01, 5'b01000, 7'd1, 8'd0)); // +8
        push(ev(0, 0, 0, 0, 1, 2'b00, 5'b10000, 7'd1, 8'd0)); // +9 reset
        push(ev(0, 0, 0, 0, 1, 2'b00, 5'b10000, 7'd1, 8'd0)); // probe
        start_at(8, 1'b1);
        drive_at(5, 1, 0, 0, 0);
        run_to(9);
        b_reset = 1'b1;
        cyc1();
        b_reset = 1'b0;
        bus.start = 1'b0;
        cyc1();
        probe = 1'b1;
        cyc1();
        probe = 1'b0;
        cyc1();
        cyc1();
        cyc1();

        // Final report
        if (exp_q.size() != 0) begin
            n_vec += exp_q.size();
            n_err += exp_q.size();
            $display("FAIL missing_events: got %0d events never seen, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
- Sequencing controller for the snake game datapath: master FSM, move-tick generation, turn queuing, per-frame collision evaluation, size/score bookkeeping.
- Drives the snake position-update logic (move/clear strobes, one-hot direction), the apple placement logic (respawn strobe) and the colour mux (game_over).
- Consumes per-pixel head-overlap flags from the display scan and the debounced direction button pulse.

Parameters:
- TICK_DIV, 1777777: master_clk cycles between snake move steps (must be >= 2).
- MAX_SIZE, 16: segment count that ends the game as a win (2..127).

Ports:
- master_clk  in  1  system clock, 50 MHz.
- B_reset  in  1  synchronous, active-high reset.
- start  in  1  level switch; 1 = play, 0 = abort/idle.
- dir_pulse  in  1  debounced single-cycle turn request, clockwise rotation.
- frame_end  in  1  single-cycle pulse after last visible pixel of a frame, synchronous to master_clk.
- hit_apple  in  1  head overlaps apple at current scan pixel.
- hit_lethal  in  1  head overlaps border or body at current scan pixel.
- move_en  out  1  single-cycle strobe: shift body, advance head in direction.
- direction  out  5  one-hot: 00010 up, 10000 right, 01000 down, 00100 left.
- body_clear  out  1  level: hold body segments off-screen.
- apple_respawn  out  1  single-cycle strobe: load new apple position.
- grow  out  1  single-cycle strobe: one segment added.
- size  out  7  current segment count.
- score  out  8  apples eaten, saturating.
- game_over  out  1  level, lethal collision occurred.
- state  out  2  00 IDLE, 01 RUN, 10 DEAD, 11 WIN.

Behaviour:
- All outputs registered. Reset applied on the edge where B_reset=1; overrides every other event.
- Reset values: state=IDLE, direction=10000, pending=10000, size=1, score=0, tick=0, latches=0, armed=0, move_en=grow=apple_respawn=game_over=0, body_clear=1.
- Priority each edge: B_reset > start==0 > lethal evaluation > apple evaluation > tick/turn.
- IDLE:
  - body_clear=1, size=1, game_over=0, direction=pending=10000.
  - start==1 -> RUN next edge; same edge clears score, tick, latches, armed; pulses apple_respawn.
- RUN:
  - body_clear=0. tick counts 0..TICK_DIV-1.
  - At tick==TICK_DIV-1: tick->0, move_en=1 next cycle, direction<=pending, armed<=1. Move period exactly TICK_DIV cycles.
  - Turn queuing: dir_pulse with pending==direction rotates pending clockwise (up->right->down->left->up). dir_pulse with pending!=direction is ignored (no 180-degree reversal within one step).
  - dir_pulse on the move_en-producing edge: applies to the new direction on the following cycle.
  - Latches: lethal_lat |= hit_lethal and apple_lat |= hit_apple every cycle.
  - On frame_end, effective flag = latch OR same-cycle input; both latches cleared.
  - Lethal set -> DEAD, game_over=1 next cycle.
  - Else apple set and armed -> grow=1, apple_respawn=1, size+1, score+1 (saturate 255), armed<=0. New size==MAX_SIZE -> WIN.
  - Apple while not armed: ignored (one growth per move step).
  - frame_end coincident with move tick: evaluation uses pre-move armed, then armed<=1.
- DEAD: move_en never asserted, game_over=1, size/score frozen, dir_pulse ignored.
- WIN: move_en never asserted, game_over=0, size==MAX_SIZE, score frozen.
- start==0 in RUN/DEAD/WIN -> IDLE next edge (IDLE values applied; score retained until next start).
- size never exceeds MAX_SIZE; score never wraps.

Test Plan:
- TICK_DIV=4. Reset, start=1 -> state=01 and one apple_respawn pulse; move_en every 4 cycles; direction=10000.
- Two dir_pulse 1 cycle apart between ticks -> direction becomes 01000 at next move_en (second pulse ignored); a later pulse -> 00100 at following move.
- hit_apple 3 cycles in one frame, then frame_end -> exactly one grow/apple_respawn; size 1->2, score 0->1. Repeat without move_en -> no change.
- hit_lethal coincident with frame_end and hit_apple -> DEAD, game_over=1, size unchanged, move_en stops.
- MAX_SIZE=3: two armed apple frames -> size=3, state=11, game_over=0, no further move_en.
- start=0 mid-RUN -> IDLE next edge, body_clear=1, size=1, score retained. B_reset mid-RUN -> all reset values next edge.
